// File: rtl/ahb_block_mover.sv
// AHB-Lite burst mover: one 128-bit block per ahb_shift_en pulse as an INCR4 word burst,
// reading SRAM into rx_block or writing tx_block back, with pointer and block-count tracking.
module ahb_block_mover #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic              ahb_shift_en,
    input  logic              ahb_mode,
    input  logic [127:0]      tx_block,
    output logic [127:0]      rx_block,
    output logic              rx_valid,
    output logic              busy,
    output logic              xfer_done,
    output logic              last_round,
    output logic              overrun,
    output logic              xfer_error,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic [1:0]        dbg_state
);
    // Handshake: an address beat is accepted, and a data phase completes, on any edge with hready=1.
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA_LAST, S_ERR} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr, dst_ptr, base;
    logic [CNT_W-1:0]  nblk, rd_cnt;
    logic              mode, dp_act;
    logic [1:0]        beat, dp_beat;
    logic [127:0]      tx_buf, rd_buf;

    logic              cfg_take, last_eff, start;
    logic [ADDR_W-1:0] src_eff, dst_eff;
    logic [1:0]        beat_nx;

    function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] k);
        case (k)
            2'd0:    word_of = blk[127:96];
            2'd1:    word_of = blk[95:64];
            2'd2:    word_of = blk[63:32];
            default: word_of = blk[31:0];
        endcase
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] blk, input logic [1:0] k,
                                              input logic [31:0] w);
        put_word = blk;
        case (k)
            2'd0:    put_word[127:96] = w;
            2'd1:    put_word[95:64]  = w;
            2'd2:    put_word[63:32]  = w;
            default: put_word[31:0]   = w;
        endcase
    endfunction

    // A configuration load in the same idle cycle as a start request is applied first.
    always_comb begin
        cfg_take = cfg_load && (state == S_IDLE);
        src_eff  = cfg_take ? src_base : src_ptr;
        dst_eff  = cfg_take ? dst_base : dst_ptr;
        last_eff = cfg_take ? 1'b0 : last_round;
        start    = (state == S_IDLE) && ahb_shift_en && (ahb_mode || !last_eff);
        beat_nx  = beat + 2'd1;
    end

    assign hsize     = 3'b010;
    assign hburst    = 3'b011;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            base       <= '0;
            nblk       <= '0;
            rd_cnt     <= '0;
            mode       <= 1'b0;
            dp_act     <= 1'b0;
            beat       <= 2'd0;
            dp_beat    <= 2'd0;
            tx_buf     <= '0;
            rd_buf     <= '0;
            rx_block   <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            xfer_done  <= 1'b0;
            last_round <= 1'b0;
            overrun    <= 1'b0;
            xfer_error <= 1'b0;
            haddr      <= '0;
            htrans     <= HT_IDLE;
            hwrite     <= 1'b0;
            hwdata     <= '0;
        end else begin
            xfer_done <= 1'b0;
            rx_valid  <= 1'b0;
            if (cfg_take) begin
                src_ptr    <= src_base;
                dst_ptr    <= dst_base;
                nblk       <= (num_blocks == '0) ? CNT_W'(1) : num_blocks;
                rd_cnt     <= '0;
                last_round <= 1'b0;
                overrun    <= 1'b0;
                xfer_error <= 1'b0;
            end
            if (ahb_shift_en && (state != S_IDLE))
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode   <= ahb_mode;
                        tx_buf <= tx_block;
                        base   <= ahb_mode ? dst_eff : src_eff;
                        haddr  <= ahb_mode ? dst_eff : src_eff;
                        htrans <= HT_NONSEQ;
                        hwrite <= ahb_mode;
                        beat   <= 2'd0;
                        dp_act <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (dp_act && hresp) begin
                        htrans     <= HT_IDLE;
                        xfer_error <= 1'b1;
                        state      <= S_ERR;
                    end else if (hready) begin
                        if (dp_act)
                            rd_buf <= put_word(rd_buf, dp_beat, hrdata);
                        dp_act  <= 1'b1;
                        dp_beat <= beat;
                        hwdata  <= word_of(tx_buf, beat);
                        if (beat == 2'd3) begin
                            htrans <= HT_IDLE;
                            state  <= S_DATA_LAST;
                        end else begin
                            beat   <= beat_nx;
                            haddr  <= base + {{(ADDR_W-4){1'b0}}, beat_nx, 2'b00};
                            htrans <= HT_SEQ;
                        end
                    end
                end
                S_DATA_LAST: begin
                    if (hresp) begin
                        xfer_error <= 1'b1;
                        state      <= S_ERR;
                    end else if (hready) begin
                        if (!mode) begin
                            rx_block <= {rd_buf[127:32], hrdata};
                            rx_valid <= 1'b1;
                            src_ptr  <= src_ptr + ADDR_W'(16);
                            if (rd_cnt != nblk)
                                rd_cnt <= rd_cnt + CNT_W'(1);
                            if (rd_cnt + CNT_W'(1) >= nblk)
                                last_round <= 1'b1;
                        end else begin
                            dst_ptr <= dst_ptr + ADDR_W'(16);
                        end
                        xfer_done <= 1'b1;
                        busy      <= 1'b0;
                        hwrite    <= 1'b0;
                        dp_act    <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    // Error recovery: report completion so the controller never waits forever.
                    xfer_done <= 1'b1;
                    busy      <= 1'b0;
                    hwrite    <= 1'b0;
                    dp_act    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
